// File: rtl/regfile_pkg.sv
// regfile_pkg: register-file geometry and helpers shared by the write arbiter and the register file
//   XLEN     data width of one register
//   AW       register address width
//   NREG     number of architectural registers
//   REG_ZERO address of the hard-wired zero register
//   GIDW     width of the exported grant index
//   DCW      width of the x0-drop counter
//   sat_inc  saturating increment for DCW-wide counters
package regfile_pkg;
  localparam int XLEN = 32;
  localparam int AW = 5;
  localparam int NREG = 32;
  localparam logic [AW-1:0] REG_ZERO = 5'd0;
  localparam int GIDW = 3;
  localparam int DCW = 16;
  function automatic logic [DCW-1:0] sat_inc(input logic [DCW-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// rr_arbiter: generic N-wide round-robin arbiter owning its pointer register
//   clk, rst   clock, synchronous active-high reset
//   req_i      request vector
//   advance_i  a grant was taken this cycle; the pointer moves to the winner
//   gnt_o      one-hot grant (zero when nothing requests)
//   idx_o      binary index of the granted requester
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  logic [IW-1:0] last_q, last_d, cand;
  // Scan from farthest to nearest after the last winner so the nearest valid request wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(last_q) + k) % N);
      if (req_i[cand]) begin
        gnt_o = '0;
        gnt_o[cand] = 1'b1;
        idx_o = cand;
      end
    end
    last_d = advance_i ? idx_o : last_q;
  end
  // Reset parks the pointer at N-1 so requester 0 wins the first contention.
  always_ff @(posedge clk)
    if (rst) last_q <= IW'(N - 1);
    else last_q <= last_d;
endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin sharing of the register-file write port among NREQ writeback sources
//   clk, rst   clock, synchronous active-high reset
//   req_valid  per-requester write pending
//   req_ready  per-requester accept (one-hot or zero, forced low during reset)
//   req_rd     per-requester destination register, packed AW bits each
//   req_data   per-requester write data, packed XLEN bits each
//   WE3/A3/WD3 register-file write port, driven one cycle after acceptance
//   grant_id   requester whose write is on the port, zero-extended
//   drop_cnt   saturating count of accepted writes to x0
module regfile_wr_arbiter #(
  parameter int NREQ = 2,
  parameter int XLEN = regfile_pkg::XLEN,
  parameter int AW = regfile_pkg::AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic                 WE3,
  output logic [AW-1:0]        A3,
  output logic [XLEN-1:0]      WD3,
  output logic [2:0]           grant_id,
  output logic [15:0]          drop_cnt
);
  import regfile_pkg::*;
  localparam int IW = $clog2(NREQ);
  logic [NREQ-1:0] gnt;
  logic [IW-1:0] win;
  logic xfer, x0;
  logic [AW-1:0] rd_w;
  logic [XLEN-1:0] data_w;
  logic we_q, we_d;
  logic [AW-1:0] a3_q, a3_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic [IW-1:0] gid_q, gid_d;
  logic [DCW-1:0] dc_q, dc_d;
  rr_arbiter #(.N(NREQ)) u_rr (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_valid),
    .advance_i(xfer),
    .gnt_o    (gnt),
    .idx_o    (win)
  );
  assign req_ready = rst ? '0 : gnt;
  assign xfer = |req_ready;
  assign rd_w = req_rd[int'(win)*AW +: AW];
  assign data_w = req_data[int'(win)*XLEN +: XLEN];
  assign x0 = rd_w == '0;
  // x0 writes are consumed and counted but never reach the port.
  always_comb begin
    we_d = xfer & ~x0;
    a3_d = xfer ? rd_w : a3_q;
    wd_d = xfer ? data_w : wd_q;
    gid_d = xfer ? win : gid_q;
    dc_d = (xfer & x0) ? sat_inc(dc_q) : dc_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      we_q <= 1'b0;
      a3_q <= '0;
      wd_q <= '0;
      gid_q <= '0;
      dc_q <= '0;
    end else begin
      we_q <= we_d;
      a3_q <= a3_d;
      wd_q <= wd_d;
      gid_q <= gid_d;
      dc_q <= dc_d;
    end
  // A write registered just before reset must not reach the register file while reset is held.
  assign WE3 = we_q & ~rst;
  assign A3 = a3_q;
  assign WD3 = wd_q;
  assign grant_id = GIDW'(gid_q);
  assign drop_cnt = dc_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed and randomized checks of the write-port arbiter for NREQ=2 and NREQ=3
module tb_regfile_wr_arbiter;
  logic clk = 1'b0;
  logic rst, rf_clr;
  always #5 clk = ~clk;
  logic [1:0] v2, rdy2;
  logic [9:0] rd2;
  logic [63:0] d2;
  logic we_2;
  logic [4:0] a3_2;
  logic [31:0] wd_2;
  logic [2:0] gid_2;
  logic [15:0] dc_2;
  logic [2:0] v3, rdy3;
  logic [14:0] rd3;
  logic [95:0] d3;
  logic we_3;
  logic [4:0] a3_3;
  logic [31:0] wd_3;
  logic [2:0] gid_3;
  logic [15:0] dc_3;
  int checks = 0, errors = 0;
  regfile_wr_arbiter #(.NREQ(2)) u2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .req_rd(rd2), .req_data(d2),
    .WE3(we_2), .A3(a3_2), .WD3(wd_2), .grant_id(gid_2), .drop_cnt(dc_2)
  );
  regfile_wr_arbiter #(.NREQ(3)) u3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3), .req_rd(rd3), .req_data(d3),
    .WE3(we_3), .A3(a3_3), .WD3(wd_3), .grant_id(gid_3), .drop_cnt(dc_3)
  );
  logic [31:0] rf2 [32];
  logic [31:0] rf3 [32];
  int obs_wr;
  always @(posedge clk)
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) begin
        rf2[i] <= '0;
        rf3[i] <= '0;
      end
      obs_wr <= 0;
    end else begin
      if (we_2) rf2[a3_2] <= wd_2;
      if (we_3) begin
        rf3[a3_3] <= wd_3;
        obs_wr <= obs_wr + 1;
      end
    end
  task automatic chk(input string tag, input logic ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    rf_clr = 1'b1;
    v2 = '0;
    v3 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rf_clr = 1'b0;
  endtask
  logic [31:0] c0, c1, pd;
  logic [4:0] pa;
  logic [2:0] pg;
  logic [31:0] cc [3];
  logic pv [3];
  logic [4:0] prd [3];
  logic [31:0] pdat [3];
  logic [31:0] erf [32];
  logic ewe, busy;
  logic [4:0] ea;
  logic [31:0] ewd;
  logic [2:0] eg;
  logic [15:0] edrop;
  int last, win, nwr;
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1;
    rf_clr = 1'b1;
    v2 = 2'b11;
    v3 = 3'b111;
    rd2 = '0;
    d2 = '0;
    rd3 = '0;
    d3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready2", rdy2 === 2'b00);
    chk("rst_ready3", rdy3 === 3'b000);
    chk("rst_we", we_2 === 1'b0);
    chk("rst_a3", a3_2 === 5'd0);
    chk("rst_wd3", wd_2 === 32'd0);
    chk("rst_gid", gid_2 === 3'd0);
    chk("rst_drop", dc_2 === 16'd0);
    rst = 1'b0;
    rf_clr = 1'b0;
    v3 = '0;
    v2 = 2'b01;
    rd2 = {5'd0, 5'd5};
    d2 = {32'd0, 32'hDEADBEEF};
    #1;
    chk("t1_ready", rdy2 === 2'b01);
    @(posedge clk); #1;
    v2 = 2'b00;
    #1;
    chk("t1_we", we_2 === 1'b1);
    chk("t1_a3", a3_2 === 5'd5);
    chk("t1_wd3", wd_2 === 32'hDEADBEEF);
    chk("t1_gid", gid_2 === 3'd0);
    chk("t1_ready_idle", rdy2 === 2'b00);
    @(posedge clk); #1; #1;
    chk("t1_we_off", we_2 === 1'b0);
    do_reset();
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < 5; i++) begin
      v2 = (i < 4) ? 2'b11 : 2'b00;
      rd2 = {5'd2, 5'd1};
      d2 = {32'hB000 + c1, 32'hA000 + c0};
      #1;
      if (i < 4) chk("t2_ready", rdy2 === 2'(1 << (i % 2)));
      if (i > 0) begin
        chk("t2_we", we_2 === 1'b1);
        chk("t2_a3", a3_2 === pa);
        chk("t2_wd3", wd_2 === pd);
        chk("t2_gid", gid_2 === pg);
      end
      if (i < 4) begin
        if (i % 2 == 0) begin
          pa = 5'd1;
          pd = 32'hA000 + c0;
          c0++;
        end else begin
          pa = 5'd2;
          pd = 32'hB000 + c1;
          c1++;
        end
        pg = 3'(i % 2);
      end
      @(posedge clk); #1;
    end
    v2 = 2'b01;
    rd2 = {5'd2, 5'd0};
    d2 = {32'h5555, 32'h1234};
    #1;
    chk("t3_ready_x0", rdy2 === 2'b01);
    chk("t3_drop0", dc_2 === 16'd0);
    @(posedge clk); #1;
    v2 = 2'b11;
    rd2 = {5'd2, 5'd3};
    d2 = {32'h5555, 32'h3333};
    #1;
    chk("t3_we_x0", we_2 === 1'b0);
    chk("t3_drop1", dc_2 === 16'd1);
    chk("t3_ready_next", rdy2 === 2'b10);
    @(posedge clk); #1;
    v2 = 2'b01;
    #1;
    chk("t3_we1", we_2 === 1'b1);
    chk("t3_a3_1", a3_2 === 5'd2);
    chk("t3_wd3_1", wd_2 === 32'h5555);
    chk("t3_gid1", gid_2 === 3'd1);
    chk("t3_ready0", rdy2 === 2'b01);
    @(posedge clk); #1;
    v2 = 2'b00;
    #1;
    chk("t3_we0", we_2 === 1'b1);
    chk("t3_a3_0", a3_2 === 5'd3);
    chk("t3_wd3_0", wd_2 === 32'h3333);
    chk("t3_gid0", gid_2 === 3'd0);
    @(posedge clk); #1;
    v2 = 2'b01;
    rd2 = {5'd0, 5'd7};
    d2 = {32'd0, 32'h7777};
    #1;
    chk("t4_ready", rdy2 === 2'b01);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t4_we_in_rst", we_2 === 1'b0);
    chk("t4_ready_in_rst", rdy2 === 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    v2 = 2'b00;
    #1;
    chk("t4_we_after_rst", we_2 === 1'b0);
    @(posedge clk); #1;
    chk("t4_rf7_old", rf2[7] === 32'd0);
    chk("t4_rf2", rf2[2] === 32'h5555);
    chk("t4_rf3", rf2[3] === 32'h3333);
    do_reset();
    rd3 = {5'd3, 5'd2, 5'd1};
    for (int j = 0; j < 3; j++) cc[j] = 0;
    for (int i = 0; i < 7; i++) begin
      v3 = (i < 6) ? 3'b111 : 3'b000;
      d3 = {32'hC000 + cc[2], 32'hB000 + cc[1], 32'hA000 + cc[0]};
      #1;
      if (i < 6) begin
        chk("t5_ready", rdy3 === 3'(1 << (i % 3)));
        chk("t5_onehot", $onehot(rdy3) === 1'b1);
      end
      if (i > 0) begin
        chk("t5_we", we_3 === 1'b1);
        chk("t5_gid", gid_3 === pg);
        chk("t5_a3", a3_3 === 5'(pg + 1));
      end
      if (i < 6) begin
        pg = 3'(i % 3);
        cc[i % 3]++;
      end
      @(posedge clk); #1;
    end
    do_reset();
    for (int i = 0; i < 3; i++) pv[i] = 1'b0;
    for (int i = 0; i < 32; i++) erf[i] = '0;
    last = 2;
    ewe = 1'b0;
    ea = '0;
    ewd = '0;
    eg = '0;
    edrop = '0;
    nwr = 0;
    busy = 1'b0;
    for (int cyc = 0; cyc < 10100; cyc++) begin
      busy = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (!pv[i] && cyc < 10000 && $urandom_range(0, 1) == 1) begin
          pv[i] = 1'b1;
          prd[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          pdat[i] = $urandom;
        end
        busy |= pv[i];
        v3[i] = pv[i];
        rd3[i*5 +: 5] = prd[i];
        d3[i*32 +: 32] = pdat[i];
      end
      win = -1;
      for (int k = 1; k <= 3; k++)
        if (win < 0 && pv[(last + k) % 3]) win = (last + k) % 3;
      #1;
      chk("t6_ready", rdy3 === ((win < 0) ? 3'b000 : 3'(1 << win)));
      chk("t6_we", we_3 === ewe);
      if (ewe) begin
        chk("t6_a3", a3_3 === ea);
        chk("t6_wd3", wd_3 === ewd);
        chk("t6_gid", gid_3 === eg);
      end
      chk("t6_drop", dc_3 === edrop);
      chk("t6_we_x0", (we_3 && (a3_3 == 5'd0)) === 1'b0);
      if (win >= 0) begin
        last = win;
        eg = 3'(win);
        if (prd[win] != 5'd0) begin
          ewe = 1'b1;
          ea = prd[win];
          ewd = pdat[win];
          erf[prd[win]] = pdat[win];
          nwr++;
        end else begin
          ewe = 1'b0;
          if (edrop != 16'hFFFF) edrop++;
        end
        pv[win] = 1'b0;
      end else begin
        ewe = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk("t6_drained", busy === 1'b0);
    chk("t6_write_count", obs_wr === nwr);
    for (int i = 0; i < 32; i++) chk("t6_regfile", rf3[i] === erf[i]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
